// File: rtl/register_scoreboard_pkg.sv
// Shared constants for the register scoreboard and its instruction decoders.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package register_scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int INSTR_W   = 32;

  // RV32/RV64 base opcodes the decoders care about
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_AMO      = 7'b0101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  reg_map_t;

  // One-hot bitmap for a register index
  function automatic reg_map_t reg_onehot(input reg_idx_t idx);
    reg_map_t m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/register_scoreboard_decode.sv
// Source/destination register decoders for a RISC-V instruction word.
// Latency: purely combinational.
// Backpressure: none; outputs follow the input word.
module read_detector
  import register_scoreboard_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic               rs1_vld_o,
  output logic               rs2_vld_o,
  output reg_idx_t           rs1_o,
  output reg_idx_t           rs2_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign funct3      = instr_i[14:12];
  assign rs1_o       = instr_i[19:15];
  assign rs2_o       = instr_i[24:20];
  assign unused_bits = ^{instr_i[31:25], instr_i[11:7]};

  // Decide which source fields the opcode actually reads
  always_comb begin
    rs1_vld_o = 1'b0;
    rs2_vld_o = 1'b0;
    unique case (opcode)
      OPC_OP, OPC_OP32, OPC_AMO, OPC_STORE, OPC_BRANCH: begin
        rs1_vld_o = 1'b1;
        rs2_vld_o = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD, OPC_JALR: begin
        rs1_vld_o = 1'b1;
      end
      // CSRRW/CSRRS/CSRRC read rs1; the immediate forms do not
      OPC_SYSTEM: begin
        rs1_vld_o = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      default: ;
    endcase
  end

endmodule

module write_detector
  import register_scoreboard_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic               rd_vld_o,
  output reg_idx_t           rd_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign funct3      = instr_i[14:12];
  assign rd_o        = instr_i[11:7];
  assign unused_bits = ^instr_i[31:15];

  // Decide whether the opcode writes rd
  always_comb begin
    rd_vld_o = 1'b0;
    unique case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
      OPC_OP_IMM, OPC_OP, OPC_OP_IMM32, OPC_OP32, OPC_AMO: begin
        rd_vld_o = 1'b1;
      end
      // ECALL/EBREAK/xRET (funct3 == 0) write nothing; CSR ops write rd
      OPC_SYSTEM: begin
        rd_vld_o = (funct3 != 3'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/register_scoreboard.sv
// In-order issue scoreboard: tracks in-flight register writes, blocks RAW/WAW/capacity hazards.
// Latency: issue_ready is combinational; pending/inflight update on the next rising edge.
// Backpressure: issue_ready drops on hazard; writeback is never stalled, bad writebacks set wb_err.
module register_scoreboard
  import register_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [INSTR_W-1:0]   issue_instr,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  pending,
  output logic [4:0]           inflight,
  output logic [31:0]          stall_cycles,
  output logic                 wb_err
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_INFLIGHT);

  reg_map_t    pending_q,  pending_d;
  logic [4:0]  inflight_q, inflight_d;
  logic [31:0] stall_q,    stall_d;
  logic        wb_err_q,   wb_err_d;

  logic     rs1_vld, rs2_vld, rd_vld;
  reg_idx_t rs1, rs2, rd;

  read_detector u_read_detector (
    .instr_i   (issue_instr),
    .rs1_vld_o (rs1_vld),
    .rs2_vld_o (rs2_vld),
    .rs1_o     (rs1),
    .rs2_o     (rs2)
  );

  write_detector u_write_detector (
    .instr_i  (issue_instr),
    .rd_vld_o (rd_vld),
    .rd_o     (rd)
  );

  reg_map_t wb_clr;
  reg_map_t pend_eff;
  logic     writes;
  logic     raw_hzd, waw_hzd, cap_hzd;
  logic     wb_hit;
  logic     issue_set;

  // Hazard check against the pending map with this cycle's writeback already removed
  always_comb begin
    wb_clr    = wb_valid ? reg_onehot(wb_reg) : '0;
    wb_clr[0] = 1'b0;
    pend_eff  = pending_q & ~wb_clr;
    writes    = rd_vld && (rd != '0);
    raw_hzd   = (rs1_vld && (rs1 != '0) && pend_eff[rs1]) ||
                (rs2_vld && (rs2 != '0) && pend_eff[rs2]);
    waw_hzd   = writes && pend_eff[rd];
    cap_hzd   = writes && (inflight_q == MAX_CNT);
    issue_ready = !(raw_hzd || waw_hzd || cap_hzd);
  end

  // Next-state: writeback clears first, then issue sets; flush wipes both
  always_comb begin
    wb_hit    = wb_valid && (wb_reg != '0) && pending_q[wb_reg];
    issue_set = issue_valid && issue_ready && writes;

    pending_d = pending_q;
    if (wb_hit) begin
      pending_d[wb_reg] = 1'b0;
    end
    if (issue_set) begin
      pending_d[rd] = 1'b1;
    end
    inflight_d = inflight_q + {4'd0, issue_set} - {4'd0, wb_hit};

    if (flush) begin
      pending_d  = '0;
      inflight_d = '0;
    end

    wb_err_d = wb_err_q || (wb_valid && !wb_hit);

    stall_d = stall_q;
    if (issue_valid && !issue_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Scoreboard state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      inflight_q <= '0;
      stall_q    <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign pending      = pending_q;
  assign inflight     = inflight_q;
  assign stall_cycles = stall_q;
  assign wb_err       = wb_err_q;

endmodule

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4: maximum outstanding register writes, range 1..31.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port issue_valid  input  1  candidate instruction present.
REQ-005 SHALL have port issue_instr  input  32  candidate RISC-V instruction word.
REQ-006 SHALL have port issue_ready  output  1  candidate may issue this cycle.
REQ-007 SHALL have port wb_valid  input  1  writeback completing this cycle.
REQ-008 SHALL have port wb_reg  input  5  destination register being written back.
REQ-009 SHALL have port flush  input  1  discard all outstanding writes.
REQ-010 SHALL have port pending  output  32  per-register in-flight write bitmap.
REQ-011 SHALL have port inflight  output  5  count of outstanding writes.
REQ-012 SHALL have port stall_cycles  output  32  saturating count of cycles with issue_valid high and issue_ready low.
REQ-013 SHALL have port wb_err  output  1  sticky: writeback seen for a non-pending register.

Function
REQ-014 Issue fires when issue_valid and issue_ready are both high in the same cycle.
REQ-015 issue_ready SHALL be combinational: low on RAW hazard (a source register read by issue_instr has its pending bit set), WAW hazard (the issue_instr destination has its pending bit set), or issue_instr writes and inflight == MAX_INFLIGHT; otherwise high.
REQ-016 Register 0 SHALL never be marked pending; reads and writes of x0 never cause a hazard.
REQ-017 Same-cycle bypass: wb_valid for register R SHALL be treated as clearing R before the hazard check, so an instruction reading R issues in that cycle.
REQ-018 Issue fire of a writing instruction to rd != 0 SHALL set pending[rd] at the next edge and increment inflight.
REQ-019 Valid writeback to a pending register SHALL clear its bit at the next edge and decrement inflight.
REQ-020 Simultaneous writeback of R and issue writing R SHALL leave pending[R] set, with inflight unchanged.
REQ-021 Writeback to a non-pending register, or to x0, SHALL change neither pending nor inflight, and SHALL set wb_err.
REQ-022 flush SHALL clear pending and inflight at the next edge, overriding issue and writeback that cycle; issue_ready is evaluated normally during the flush cycle, but its fire is discarded.
REQ-023 inflight SHALL always equal popcount(pending) and SHALL never exceed MAX_INFLIGHT.
REQ-024 stall_cycles SHALL saturate at 32'hFFFFFFFF; flush SHALL NOT clear it.
REQ-025 Instructions that neither read nor write registers SHALL issue whenever issue_valid is high, unless a WAW or capacity condition applies.

Reset
REQ-026 While rst is high: pending = 0, inflight = 0, stall_cycles = 0, wb_err = 0, asynchronously, with no clock required.
REQ-027 Reset asserted mid-operation SHALL discard all outstanding writes; writebacks arriving after reset for those writes SHALL set wb_err.

Structure
REQ-028 A shared package SHALL hold REG_IDX_W = 5, NUM_REGS = 32 and INSTR_W = 32.
REQ-029 Source decoding SHALL reuse the existing read_detector, and destination decoding the existing write_detector, each instantiated once on issue_instr.
REQ-030 State SHALL be the pending bitmap, the inflight counter, the stall counter and the wb_err flag only; no additional pipeline stage is permitted.

Verification
REQ-031 After reset, issue "addi x5,x0,1" -> issue_ready = 1; next cycle pending = 32'h20 and inflight = 1.
REQ-032 With x5 pending, issue "add x6,x5,x1" for 3 cycles -> ready = 0 and stall_cycles = 3; on wb_reg = 5 -> ready = 1 in that same cycle.
REQ-033 Fill 4 distinct destinations x1..x4, then offer "addi x7,x0,0" -> ready = 0 until one writeback completes.
REQ-034 Same-cycle writeback of x5 and issue "addi x5,x0,2" -> pending[5] stays 1 and inflight unchanged.
REQ-035 With 3 writes pending, assert flush -> pending = 0 and inflight = 0; a later wb_reg = 3 -> wb_err = 1.
REQ-036 Issue "add x0,x0,x0" -> pending stays 0 and issue_ready stays 1.
